input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Upstream stage of the game control FSM; converts raw, already-inverted push-button levels (left, right, rotate, go) into clean, held move requests.
- Per button: 2-flop synchroniser, debounce, press-edge detection.
- Left/right additionally auto-repeat while held; rotate and go fire once per press.
- Requests stay asserted until the control FSM pulses consume, so single-cycle events are never lost while the FSM is busy drawing or in collision detection.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable synchronised cycles required to accept a level change (5 ms at 50 MHz).
- REPEAT_DELAY, 12500000: cycles from accepted press to first auto-repeat event (250 ms).
- REPEAT_PERIOD, 5000000: cycles between subsequent auto-repeat events (100 ms).
- CNT_W, 24: counter width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- btn_left  in  1  raw left button, active-high, asynchronous to clk
- btn_right  in  1  raw right button, active-high, asynchronous
- btn_rotate  in  1  raw rotate button, active-high, asynchronous
- btn_go  in  1  raw go/start button, active-high, asynchronous
- consume  in  1  single-cycle pulse from control FSM; clears all pending move requests
- left  out  1  pending left request
- right  out  1  pending right request
- rotate  out  1  pending rotate request
- go  out  1  debounced go level (no latching, no repeat)

Behaviour:
- Reset (asynchronous, takes effect immediately): all outputs 0; synchronisers, stable levels, counters and pending flags 0; all channel FSMs in IDLE. Reset mid-hold discards all pending and repeat state. After release, a still-held button counts as a new press once it passes debounce.
- Synchroniser: two flops per button, so raw input reaches sync2 two edges after sampling.
- Debounce, per channel:
  - Counter clears whenever sync2 == stable.
  - Otherwise the counter increments. On the edge where counter == DEBOUNCE_CYCLES-1, stable <= sync2 and the counter clears.
  - A raw high first sampled at edge N gives stable high at edge N+1+DEBOUNCE_CYCLES.
  - Any mismatch shorter than DEBOUNCE_CYCLES produces no change.
- Channel FSM (left and right; rotate uses IDLE/HELD only):
  - IDLE: on stable rise, emit event and go to DELAY; counter = 0.
  - DELAY: count. At REPEAT_DELAY-1, emit event and go to REPEAT; counter = 0.
  - REPEAT: count. At REPEAT_PERIOD-1, emit event and restart the count.
  - DELAY/REPEAT/HELD: on stable low, go to IDLE and emit nothing.
  - Rotate: IDLE goes to HELD on a rise, with the event emitted; HELD goes to IDLE on a fall.
  - Events are one-cycle internal strobes and are combinational from the FSM.
- Pending flags (registered; each is the corresponding output):
  - An event sets its flag on the same edge: a press accepted at edge M gives output high after edge M+1.
  - consume clears all three flags.
  - Event and consume in the same cycle: the event wins and the flag ends at 1.
  - A left event clears a pending right, and vice versa (the latest direction wins).
  - Simultaneous left and right events leave both flags 0 (a pending one is also cleared).
  - Repeat events while a flag is already set are absorbed: no counting, no queue.
- go = stable level of the go channel, registered, no repeat.
- Counters saturate-free: an FSM never holds a count beyond its terminal value.

Decomposition:
- Shared package: channel-state encodings (IDLE, DELAY, REPEAT, HELD) as 2-bit localparams; default timing constants for 50 MHz.
- Sub-module button_channel (parameter REPEAT_EN) holds the synchroniser, debounce counter, repeat FSM and event output.
- Top instantiates four button_channel (go and rotate with REPEAT_EN=0) plus the pending-flag logic.

Test Plan:
Bench parameters DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
- Clean press: btn_left 0→1 sampled at edge 0 and held; consume never asserted → left rises after edge 6, stays 1; right/rotate stay 0.
- Glitch reject: btn_rotate high for 3 cycles then low → rotate stays 0 throughout; debounce counter returns to 0.
- Auto-repeat: btn_right held; bench pulses consume the cycle after each right rise → right rises at edges 6, 16, 21, 26, 31 while held. After release passes debounce, no further rises.
- Consume collision: consume asserted on the exact cycle of a left event → left is 1 afterwards. consume one cycle later → left is 0.
- Direction conflict: left pending, then right pressed → right=1, left=0 on the event edge. Both pressed in the same cycle → both 0.
- Async reset mid-repeat: reset pulsed while btn_left held in REPEAT → all outputs 0 immediately. After reset deasserts, left rises 2+DEBOUNCE_CYCLES+1 edges later, as a fresh press.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : input_conditioner_pkg
// Description : Shared definitions for the push-button input conditioner.
//               Per-channel state encodings, button indices and default
//               timing constants for a 50 MHz system clock.
// Revision    : 1.0 - initial release
// ============================================================================
package input_conditioner_pkg;

    // Channel FSM state encoding
    typedef logic [1:0] chan_state_t;

    localparam chan_state_t c_ST_IDLE   = 2'd0;
    localparam chan_state_t c_ST_DELAY  = 2'd1;
    localparam chan_state_t c_ST_REPEAT = 2'd2;
    localparam chan_state_t c_ST_HELD   = 2'd3;

    // Button channel indices
    localparam int c_NUM_BTN    = 4;
    localparam int c_BTN_LEFT   = 0;
    localparam int c_BTN_RIGHT  = 1;
    localparam int c_BTN_ROTATE = 2;
    localparam int c_BTN_GO     = 3;

    // Default timing at 50 MHz
    localparam int c_DEBOUNCE_CYCLES = 250000;    // 5 ms
    localparam int c_REPEAT_DELAY    = 12500000;  // 250 ms
    localparam int c_REPEAT_PERIOD   = 5000000;   // 100 ms
    localparam int c_CNT_W           = 24;

endpackage
`default_nettype wire

// File: rtl/input_conditioner_button_channel.sv
`default_nettype none
// ============================================================================
// Module      : button_channel
// Description : One push-button channel: 2-flop synchroniser, debounce
//               counter and press FSM. With REPEAT_EN set the FSM emits an
//               event on press, after REPEAT_DELAY and then every
//               REPEAT_PERIOD while held; otherwise one event per press.
// Ports       : clk     - system clock
//               reset   - asynchronous active-high reset
//               i_btn   - raw button level, asynchronous to clk
//               o_event - one-cycle press/repeat strobe (combinational)
//               o_level - debounced button level
// Revision    : 1.0 - initial release
// ============================================================================
module button_channel
    import input_conditioner_pkg::*;
#(
    parameter int CNT_W           = c_CNT_W,
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = c_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = c_REPEAT_PERIOD,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_event,
    output logic o_level
);

    localparam logic [CNT_W-1:0] c_DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] c_PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_stable;
    logic [CNT_W-1:0]  r_db_cnt;
    chan_state_t       r_state;
    logic [CNT_W-1:0]  r_rep_cnt;

    // Synchroniser and debounce: the stable level only follows sync2 after
    // DEBOUNCE_CYCLES consecutive mismatching cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_stable) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_DB_LAST) begin
                r_stable <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + c_CNT_ONE;
            end
        end
    end

    // IDLE with a high stable level only occurs in the cycle right after the
    // rise, since every other state returns to IDLE on a stable low.
    always_comb begin
        o_event = 1'b0;
        case (r_state)
            c_ST_IDLE:   o_event = r_stable;
            c_ST_DELAY:  o_event = r_stable && (r_rep_cnt == c_DLY_LAST);
            c_ST_REPEAT: o_event = r_stable && (r_rep_cnt == c_PER_LAST);
            default:     o_event = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_rep_cnt <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_rep_cnt <= '0;
                    if (r_stable) begin
                        r_state <= REPEAT_EN ? c_ST_DELAY : c_ST_HELD;
                    end
                end
                c_ST_DELAY: begin
                    if (!r_stable) begin
                        r_state   <= c_ST_IDLE;
                        r_rep_cnt <= '0;
                    end else if (r_rep_cnt == c_DLY_LAST) begin
                        r_state   <= c_ST_REPEAT;
                        r_rep_cnt <= '0;
                    end else begin
                        r_rep_cnt <= r_rep_cnt + c_CNT_ONE;
                    end
                end
                c_ST_REPEAT: begin
                    if (!r_stable) begin
                        r_state   <= c_ST_IDLE;
                        r_rep_cnt <= '0;
                    end else if (r_rep_cnt == c_PER_LAST) begin
                        r_rep_cnt <= '0;
                    end else begin
                        r_rep_cnt <= r_rep_cnt + c_CNT_ONE;
                    end
                end
                c_ST_HELD: begin
                    r_rep_cnt <= '0;
                    if (!r_stable) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= c_ST_IDLE;
                    r_rep_cnt <= '0;
                end
            endcase
        end
    end

    assign o_level = r_stable;

endmodule
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : input_conditioner
// Description : Converts raw push-button levels into held move requests for
//               the game control FSM. Left/right auto-repeat, rotate fires
//               once per press; requests persist until consumed.
// Ports       : clk        - system clock
//               reset      - asynchronous active-high reset
//               btn_left   - raw left button
//               btn_right  - raw right button
//               btn_rotate - raw rotate button
//               btn_go     - raw go/start button
//               consume    - pulse clearing all pending move requests
//               left       - pending left request
//               right      - pending right request
//               rotate     - pending rotate request
//               go         - debounced go level
// Revision    : 1.0 - initial release
// ============================================================================
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = c_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = c_REPEAT_PERIOD,
    parameter int CNT_W           = c_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_rotate,
    input  logic btn_go,
    input  logic consume,
    output logic left,
    output logic right,
    output logic rotate,
    output logic go
);

    logic [c_NUM_BTN-1:0] w_btn;
    logic [c_NUM_BTN-1:0] w_event;
    logic [c_NUM_BTN-1:0] w_level;
    logic                 w_ev_left;
    logic                 w_ev_right;
    logic                 w_ev_rotate;
    logic                 w_unused;

    logic r_left;
    logic r_right;
    logic r_rotate;

    assign w_btn = {btn_go, btn_rotate, btn_right, btn_left};

    generate
        for (genvar g = 0; g < c_NUM_BTN; g++) begin : g_chan
            button_channel #(
                .CNT_W           (CNT_W),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD),
                .REPEAT_EN       ((g == c_BTN_LEFT) || (g == c_BTN_RIGHT))
            ) u_chan (
                .clk     (clk),
                .reset   (reset),
                .i_btn   (w_btn[g]),
                .o_event (w_event[g]),
                .o_level (w_level[g])
            );
        end
    endgenerate

    assign w_ev_left   = w_event[c_BTN_LEFT];
    assign w_ev_right  = w_event[c_BTN_RIGHT];
    assign w_ev_rotate = w_event[c_BTN_ROTATE];

    // Only the go level and the move events are consumed downstream.
    assign w_unused = &{1'b0, w_level[c_BTN_ROTATE:c_BTN_LEFT], w_event[c_BTN_GO]};

    // Pending requests. Events take priority over consume; opposite
    // directions cancel so the most recent direction wins, and a
    // simultaneous left+right press cancels both.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_left   <= 1'b0;
            r_right  <= 1'b0;
            r_rotate <= 1'b0;
        end else begin
            if (w_ev_left && w_ev_right) begin
                r_left  <= 1'b0;
                r_right <= 1'b0;
            end else if (w_ev_left) begin
                r_left  <= 1'b1;
                r_right <= 1'b0;
            end else if (w_ev_right) begin
                r_left  <= 1'b0;
                r_right <= 1'b1;
            end else if (consume) begin
                r_left  <= 1'b0;
                r_right <= 1'b0;
            end

            if (w_ev_rotate) begin
                r_rotate <= 1'b1;
            end else if (consume) begin
                r_rotate <= 1'b0;
            end
        end
    end

    assign left   = r_left;
    assign right  = r_right;
    assign rotate = r_rotate;
    assign go     = w_level[c_BTN_GO];

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_conditioner
// Description : Directed self-checking bench for input_conditioner with
//               DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
//               "Edge 0" is the first clock edge that samples a new input.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_conditioner;

    localparam int c_DB  = 4;
    localparam int c_RD  = 10;
    localparam int c_RP  = 5;

    logic clk        = 1'b0;
    logic reset      = 1'b1;
    logic btn_left   = 1'b0;
    logic btn_right  = 1'b0;
    logic btn_rotate = 1'b0;
    logic btn_go     = 1'b0;
    logic consume    = 1'b0;
    logic left;
    logic right;
    logic rotate;
    logic go;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    input_conditioner #(
        .DEBOUNCE_CYCLES (c_DB),
        .REPEAT_DELAY    (c_RD),
        .REPEAT_PERIOD   (c_RP),
        .CNT_W           (24)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_rotate (btn_rotate),
        .btn_go     (btn_go),
        .consume    (consume),
        .left       (left),
        .right      (right),
        .rotate     (rotate),
        .go         (go)
    );

    // Advance to 1 ns past the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        btn_left   = 1'b0;
        btn_right  = 1'b0;
        btn_rotate = 1'b0;
        btn_go     = 1'b0;
        consume    = 1'b0;
        #2 reset = 1'b1;
        step();
        step();
        #2 reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if ({left, right, rotate, go} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: {l,r,rot,go}=%b expected 0000", {left, right, rotate, go});
        end
    endtask

    task automatic test_clean_press();
        do_reset();
        btn_left = 1'b1;
        repeat (6) step();  // past edge 5
        checks++;
        if (left !== 1'b0) begin
            errors++;
            $display("FAIL clean_press_early: left=%b expected 0", left);
        end
        step();             // past edge 6
        checks++;
        if ({left, right, rotate} !== 3'b100) begin
            errors++;
            $display("FAIL clean_press_rise: {l,r,rot}=%b expected 100", {left, right, rotate});
        end
        for (int k = 7; k <= 30; k++) begin
            step();
            checks++;
            if ({left, right, rotate} !== 3'b100) begin
                errors++;
                $display("FAIL clean_press_hold edge %0d: {l,r,rot}=%b expected 100", k, {left, right, rotate});
            end
        end
        btn_left = 1'b0;
        repeat (8) step();
        consume = 1'b1;
        step();
        consume = 1'b0;
        repeat (10) step();
        checks++;
        if (left !== 1'b0) begin
            errors++;
            $display("FAIL clean_press_released: left=%b expected 0", left);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        btn_rotate = 1'b1;
        repeat (3) step();
        btn_rotate = 1'b0;
        for (int k = 3; k <= 15; k++) begin
            step();
            checks++;
            if (rotate !== 1'b0) begin
                errors++;
                $display("FAIL glitch_rotate edge %0d: rotate=%b expected 0", k, rotate);
            end
        end
        checks++;
        if (dut.g_chan[2].u_chan.r_db_cnt !== 24'd0) begin
            errors++;
            $display("FAIL glitch_db_cnt: cnt=%0d expected 0", dut.g_chan[2].u_chan.r_db_cnt);
        end
    endtask

    task automatic test_rotate_once();
        do_reset();
        btn_rotate = 1'b1;
        repeat (7) step();  // past edge 6
        checks++;
        if (rotate !== 1'b1) begin
            errors++;
            $display("FAIL rotate_rise: rotate=%b expected 1", rotate);
        end
        consume = 1'b1;
        step();
        consume = 1'b0;
        for (int k = 7; k <= 35; k++) begin
            checks++;
            if (rotate !== 1'b0) begin
                errors++;
                $display("FAIL rotate_no_repeat edge %0d: rotate=%b expected 0", k, rotate);
            end
            step();
        end
    endtask

    task automatic test_auto_repeat();
        logic exp_r;
        logic cons_next;
        do_reset();
        cons_next = 1'b0;
        btn_right = 1'b1;
        for (int k = 0; k <= 50; k++) begin
            consume = cons_next;
            if (k == 30) btn_right = 1'b0;
            step();
            exp_r = (k == 6) || (k == 16) || (k == 21) || (k == 26) || (k == 31);
            checks++;
            if ({left, right} !== {1'b0, exp_r}) begin
                errors++;
                $display("FAIL auto_repeat edge %0d: {l,r}=%b expected %b", k, {left, right}, {1'b0, exp_r});
            end
            cons_next = exp_r;
        end
        consume = 1'b0;
    endtask

    task automatic test_consume_collision();
        do_reset();
        btn_left = 1'b1;
        repeat (6) step();  // past edge 5
        consume = 1'b1;
        step();             // edge 6: event and consume together
        consume = 1'b0;
        checks++;
        if (left !== 1'b1) begin
            errors++;
            $display("FAIL consume_collision: left=%b expected 1", left);
        end
        consume  = 1'b1;
        btn_left = 1'b0;
        step();             // edge 7
        consume = 1'b0;
        checks++;
        if (left !== 1'b0) begin
            errors++;
            $display("FAIL consume_after: left=%b expected 0", left);
        end
        repeat (12) step();
        checks++;
        if (left !== 1'b0) begin
            errors++;
            $display("FAIL consume_no_late_event: left=%b expected 0", left);
        end
    endtask

    task automatic test_direction_conflict();
        // Later right press overrides pending left
        do_reset();
        btn_left = 1'b1;
        repeat (7) step();  // past edge 6
        btn_right = 1'b1;   // sampled at edge 7, event at edge 13
        repeat (6) step();  // past edge 12
        checks++;
        if ({left, right} !== 2'b10) begin
            errors++;
            $display("FAIL dir_before: {l,r}=%b expected 10", {left, right});
        end
        step();             // past edge 13
        checks++;
        if ({left, right} !== 2'b01) begin
            errors++;
            $display("FAIL dir_override: {l,r}=%b expected 01", {left, right});
        end

        // Left delay event coincides with right press event, left pending
        do_reset();
        btn_left = 1'b1;
        repeat (10) step(); // past edge 9
        btn_right = 1'b1;   // sampled at edge 10, event at edge 16
        repeat (6) step();  // past edge 15
        checks++;
        if ({left, right} !== 2'b10) begin
            errors++;
            $display("FAIL dir_pending_before: {l,r}=%b expected 10", {left, right});
        end
        step();             // past edge 16
        checks++;
        if ({left, right} !== 2'b00) begin
            errors++;
            $display("FAIL dir_pending_cancel: {l,r}=%b expected 00", {left, right});
        end

        // Both pressed in the same cycle
        do_reset();
        btn_left  = 1'b1;
        btn_right = 1'b1;
        repeat (7) step();  // past edge 6
        checks++;
        if ({left, right} !== 2'b00) begin
            errors++;
            $display("FAIL dir_simultaneous: {l,r}=%b expected 00", {left, right});
        end
    endtask

    task automatic test_go();
        do_reset();
        btn_go = 1'b1;
        repeat (5) step();  // past edge 4
        checks++;
        if (go !== 1'b0) begin
            errors++;
            $display("FAIL go_early: go=%b expected 0", go);
        end
        step();             // past edge 5
        checks++;
        if ({left, right, rotate, go} !== 4'b0001) begin
            errors++;
            $display("FAIL go_level: {l,r,rot,go}=%b expected 0001", {left, right, rotate, go});
        end
        repeat (10) step(); // past edge 15
        btn_go = 1'b0;      // sampled at edge 16, low after edge 21
        repeat (5) step();  // past edge 20
        checks++;
        if (go !== 1'b1) begin
            errors++;
            $display("FAIL go_hold: go=%b expected 1", go);
        end
        step();             // past edge 21
        checks++;
        if (go !== 1'b0) begin
            errors++;
            $display("FAIL go_release: go=%b expected 0", go);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        btn_left = 1'b1;
        btn_go   = 1'b1;
        repeat (19) step(); // past edge 18, left channel in REPEAT
        checks++;
        if ({left, go} !== 2'b11) begin
            errors++;
            $display("FAIL areset_before: {l,go}=%b expected 11", {left, go});
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({left, right, rotate, go} !== 4'b0000) begin
            errors++;
            $display("FAIL areset_immediate: {l,r,rot,go}=%b expected 0000", {left, right, rotate, go});
        end
        step();
        step();
        #2 reset = 1'b0;
        repeat (6) step();
        checks++;
        if ({left, go} !== 2'b01) begin
            errors++;
            $display("FAIL areset_repress_early: {l,go}=%b expected 01", {left, go});
        end
        step();
        checks++;
        if ({left, go} !== 2'b11) begin
            errors++;
            $display("FAIL areset_repress: {l,go}=%b expected 11", {left, go});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_rotate_once();
        test_auto_repeat();
        test_consume_collision();
        test_direction_conflict();
        test_go();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
